pio_in_edge_irq: RTL

- Parametrised successor to the team's read-only input PIO.
- Avalon-MM slave that:
  - samples a DATA_WIDTH-bit input bus through a synchroniser;
  - records per-bit edges in a sticky edge-capture register;
  - raises a maskable level interrupt.
- Sits between board/fabric status inputs (switches, keys, peripheral flags) and the processor's Avalon interconnect.

---
 rtl/pio_pkg.sv | 22 ++
 rtl/pio_sync_edge.sv | 52 +++++
 rtl/pio_in_edge_irq.sv | 97 +++++++++
 3 files changed

// File: rtl/pio_pkg.sv
// Shared constants for the edge-capturing input PIO: the bus width, the
// register map, and the encodings of the EDGE_TYPE and CLEAR_MODE parameters.
package pio_pkg;

  localparam int unsigned BUS_W = 32;

  // Word addresses of the register map
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Values of the EDGE_TYPE parameter
  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  // Values of the CLEAR_MODE parameter
  localparam int unsigned CLR_W1C = 0;
  localparam int unsigned CLR_ANY = 1;

endpackage

// File: rtl/pio_sync_edge.sv
// Synchroniser plus edge detector, vectorised over WIDTH input bits.
// Each bit passes through SYNC_STAGES flops and then one prev flop. The
// edge selected by EDGE_TYPE comes out as a one-cycle pulse.
//   clk, reset_n   : clock and asynchronous active-low reset
//   async_i        : asynchronous input bits
//   sync_out_o     : synchronised inputs, taken from the last sync flop
//   edge_pulse_c_o : combinational edge pulse, formed from flop outputs
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_out_o,
  output logic [WIDTH-1:0] edge_pulse_c_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;

  // Shift chain: stage 0 samples the pins, and prev trails the last stage by one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out_o = sync_q[SYNC_STAGES-1];
  assign rise       = sync_out_o & ~prev_q;
  assign fall       = ~sync_out_o & prev_q;

  // Edge selection is fixed at elaboration time
  always_comb begin
    edge_pulse_c_o = rise;
    if (EDGE_TYPE == EDGE_FALLING) begin
      edge_pulse_c_o = fall;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_pulse_c_o = rise | fall;
    end
  end

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM read-only input PIO with sticky per-bit edge capture and a
// maskable level interrupt.
//   clk, reset_n : clock and asynchronous active-low reset
//   address      : word address (0 data, 1 reserved, 2 mask, 3 edgecapture)
//   chipselect   : slave select, which qualifies write
//   write        : write strobe
//   writedata    : write data; bits above DATA_WIDTH are ignored
//   readdata     : registered read data, one cycle of latency, no read strobe
//   in_port      : asynchronous external inputs
//   irq          : level interrupt, OR of (edgecapture & interruptmask)
module pio_in_edge_irq
  import pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISING,
  parameter int unsigned CLEAR_MODE  = CLR_W1C
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic [BUS_W-1:0]      writedata,
  output logic [BUS_W-1:0]      readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] sync_out;
  logic [DATA_WIDTH-1:0] edge_pulse;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] ecap_q, ecap_d;
  logic [DATA_WIDTH-1:0] clr_bits;
  logic [BUS_W-1:0]      rdata_q, rdata_d;
  logic                  wr_en;
  logic                  unused_wdata;

  pio_sync_edge #(
    .WIDTH      (DATA_WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk           (clk),
    .reset_n       (reset_n),
    .async_i       (in_port),
    .sync_out_o    (sync_out),
    .edge_pulse_c_o(edge_pulse)
  );

  assign wr_en = chipselect & write;

  // Writedata bits above DATA_WIDTH have no destination
  assign unused_wdata = ^writedata;

  // Register-file next state and read mux
  always_comb begin
    mask_d   = mask_q;
    clr_bits = '0;
    rdata_d  = '0;

    if (wr_en && (address == ADDR_MASK)) begin
      mask_d = writedata[DATA_WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGE)) begin
      clr_bits = (CLEAR_MODE == CLR_ANY) ? '1 : writedata[DATA_WIDTH-1:0];
    end

    // Set is applied after clear, so an edge that coincides with a clear is kept
    ecap_d = (ecap_q & ~clr_bits) | edge_pulse;

    case (address)
      ADDR_DATA: rdata_d = BUS_W'(sync_out);
      ADDR_MASK: rdata_d = BUS_W'(mask_q);
      ADDR_EDGE: rdata_d = BUS_W'(ecap_q);
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q  <= '0;
      ecap_q  <= '0;
      rdata_q <= '0;
    end else begin
      mask_q  <= mask_d;
      ecap_q  <= ecap_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;

  // Formed only from flop outputs, so irq does not glitch
  assign irq = |(ecap_q & mask_q);

endmodule
